// File: rtl/uart_reg_alu_system_pkg.sv
// Shared types for the UART register/ALU system: command codes, ALU functions and FSM states.
package uart_reg_alu_system_pkg;

  typedef enum logic [7:0] {
    CMD_WRITE = 8'hAA,
    CMD_READ  = 8'hBB,
    CMD_OP    = 8'hCC,
    CMD_FUNC  = 8'hDD
  } cmd_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_MUL  = 4'h2,
    ALU_DIV  = 4'h3,
    ALU_AND  = 4'h4,
    ALU_OR   = 4'h5,
    ALU_NAND = 4'h6,
    ALU_NOR  = 4'h7,
    ALU_XOR  = 4'h8,
    ALU_XNOR = 4'h9,
    ALU_EQ   = 4'hA,
    ALU_GT   = 4'hB,
    ALU_LT   = 4'hC,
    ALU_SHR  = 4'hD,
    ALU_SHL  = 4'hE,
    ALU_ZERO = 4'hF
  } alu_func_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_RD_ADDR,
    ST_OP_A,
    ST_OP_B,
    ST_FUNC
  } cmd_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_reg_alu_system_rx.sv
// UART receiver: input synchroniser, start-edge detect, mid-bit sampler, even-parity and stop checks.
module uart_reg_alu_system_rx
  import uart_reg_alu_system_pkg::*;
#(
  parameter int DATA_WIDTH               = 8,
  parameter int SYNCHRONIZER_STAGE_COUNT = 2,
  parameter int PRESCALE                 = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_serial,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_parity_error,
  output logic                  o_frame_error
);

  localparam int CW = $clog2(PRESCALE);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] MID_CYC  = CW'(PRESCALE / 2);
  localparam logic [CW-1:0] LAST_CYC = CW'(PRESCALE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  logic [SYNCHRONIZER_STAGE_COUNT-1:0] r_sync;
  logic                  r_prev;
  rx_state_e             r_state, w_next;
  logic [CW-1:0]         r_cnt;
  logic [BW-1:0]         r_bit;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par;
  logic                  w_line, w_mid, w_end, w_parity_ok;

  assign w_line      = r_sync[SYNCHRONIZER_STAGE_COUNT-1];
  assign w_mid       = (r_cnt == MID_CYC);
  assign w_end       = (r_cnt == LAST_CYC);
  assign w_parity_ok = ~(^r_shift ^ r_par);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      RX_IDLE:   if (r_prev && !w_line) w_next = RX_START;
      RX_START:  if (w_mid && w_line) w_next = RX_IDLE;
                 else if (w_end)      w_next = RX_DATA;
      RX_DATA:   if (w_end && r_bit == LAST_BIT) w_next = RX_PARITY;
      RX_PARITY: if (w_end) w_next = RX_STOP;
      RX_STOP:   if (w_mid) w_next = RX_IDLE;
      default:   w_next = RX_IDLE;
    endcase
  end

  // The edge-detect cycle counts as cycle 0 of the start bit, so the counter enters START at 1.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync         <= '1;
      r_prev         <= 1'b1;
      r_state        <= RX_IDLE;
      r_cnt          <= '0;
      r_bit          <= '0;
      r_shift        <= '0;
      r_par          <= 1'b0;
      o_data         <= '0;
      o_valid        <= 1'b0;
      o_parity_error <= 1'b0;
      o_frame_error  <= 1'b0;
    end else begin
      r_sync         <= {r_sync[SYNCHRONIZER_STAGE_COUNT-2:0], i_serial};
      r_prev         <= w_line;
      r_state        <= w_next;
      o_valid        <= 1'b0;
      o_parity_error <= 1'b0;
      o_frame_error  <= 1'b0;
      if (r_state == RX_IDLE) r_cnt <= CW'(1);
      else                    r_cnt <= w_end ? '0 : r_cnt + 1'b1;
      if (r_state == RX_START) r_bit <= '0;
      if (r_state == RX_DATA && w_mid) r_shift <= {w_line, r_shift[DATA_WIDTH-1:1]};
      if (r_state == RX_DATA && w_end) r_bit <= r_bit + 1'b1;
      if (r_state == RX_PARITY && w_mid) r_par <= w_line;
      if (r_state == RX_STOP && w_mid) begin
        o_data         <= r_shift;
        o_valid        <= w_line && w_parity_ok;
        o_parity_error <= ~w_parity_ok;
        o_frame_error  <= ~w_line;
      end
    end
  end

endmodule

// File: rtl/uart_reg_alu_system.sv
// UART-controlled register file and ALU: decodes command frames, replies over a serial TX line.
module uart_reg_alu_system
  import uart_reg_alu_system_pkg::*;
#(
  parameter int DATA_WIDTH               = 8,
  parameter int REGISTER_FILE_DEPTH      = 16,
  parameter int SYNCHRONIZER_STAGE_COUNT = 2,
  parameter int PRESCALE                 = 8
) (
  input  logic reference_clk,
  input  logic reset,
  input  logic serial_data_in,
  output logic serial_data_out,
  output logic parity_error,
  output logic frame_error
);

  localparam int RW  = 2 * DATA_WIDTH;
  localparam int AW  = $clog2(REGISTER_FILE_DEPTH);
  localparam int CW  = $clog2(PRESCALE);
  localparam int TBW = $clog2(DATA_WIDTH + 3);
  localparam logic [CW-1:0]  LAST_CYC = CW'(PRESCALE - 1);
  localparam logic [TBW-1:0] LAST_BIT = TBW'(DATA_WIDTH + 2);

  logic [DATA_WIDTH-1:0] w_rx_data;
  logic                  w_rx_valid;

  uart_reg_alu_system_rx #(
    .DATA_WIDTH              (DATA_WIDTH),
    .SYNCHRONIZER_STAGE_COUNT(SYNCHRONIZER_STAGE_COUNT),
    .PRESCALE                (PRESCALE)
  ) u_rx (
    .i_clk         (reference_clk),
    .i_rst_n       (reset),
    .i_serial      (serial_data_in),
    .o_data        (w_rx_data),
    .o_valid       (w_rx_valid),
    .o_parity_error(parity_error),
    .o_frame_error (frame_error)
  );

  logic [DATA_WIDTH-1:0] r_regs [REGISTER_FILE_DEPTH];
  cmd_state_e            r_state, w_next;
  logic [AW-1:0]         r_addr;

  logic                  w_wr_en, w_addr_load, w_reply_req, w_reply_two;
  logic [AW-1:0]         w_wr_addr;
  logic [DATA_WIDTH-1:0] w_wr_data;
  logic [RW-1:0]         w_reply_data, w_alu_a, w_alu_b, w_alu_res;
  alu_func_e             w_func;

  assign w_alu_a = {{DATA_WIDTH{1'b0}}, r_regs[0]};
  assign w_alu_b = {{DATA_WIDTH{1'b0}}, r_regs[1]};
  assign w_func  = alu_func_e'(w_rx_data[3:0]);

  always_comb begin
    w_alu_res = '0;
    unique case (w_func)
      ALU_ADD:  w_alu_res = w_alu_a + w_alu_b;
      ALU_SUB:  w_alu_res = w_alu_a - w_alu_b;
      ALU_MUL:  w_alu_res = w_alu_a * w_alu_b;
      ALU_DIV:  w_alu_res = (w_alu_b == '0) ? '0 : w_alu_a / w_alu_b;
      ALU_AND:  w_alu_res = w_alu_a & w_alu_b;
      ALU_OR:   w_alu_res = w_alu_a | w_alu_b;
      ALU_NAND: w_alu_res = ~(w_alu_a & w_alu_b);
      ALU_NOR:  w_alu_res = ~(w_alu_a | w_alu_b);
      ALU_XOR:  w_alu_res = w_alu_a ^ w_alu_b;
      ALU_XNOR: w_alu_res = ~(w_alu_a ^ w_alu_b);
      ALU_EQ:   w_alu_res = {{(RW-1){1'b0}}, w_alu_a == w_alu_b};
      ALU_GT:   w_alu_res = {{(RW-1){1'b0}}, w_alu_a > w_alu_b};
      ALU_LT:   w_alu_res = {{(RW-1){1'b0}}, w_alu_a < w_alu_b};
      ALU_SHR:  w_alu_res = w_alu_a >> 1;
      ALU_SHL:  w_alu_res = w_alu_a << 1;
      default:  w_alu_res = '0;
    endcase
  end

  // CC writes its operands as they arrive, so CC and DD share the FUNC state.
  always_comb begin
    w_next       = r_state;
    w_wr_en      = 1'b0;
    w_wr_addr    = '0;
    w_wr_data    = w_rx_data;
    w_addr_load  = 1'b0;
    w_reply_req  = 1'b0;
    w_reply_two  = 1'b0;
    w_reply_data = '0;
    if (w_rx_valid) begin
      unique case (r_state)
        ST_IDLE: begin
          case (w_rx_data)
            CMD_WRITE: w_next = ST_WR_ADDR;
            CMD_READ:  w_next = ST_RD_ADDR;
            CMD_OP:    w_next = ST_OP_A;
            CMD_FUNC:  w_next = ST_FUNC;
            default:   w_next = ST_IDLE;
          endcase
        end
        ST_WR_ADDR: begin
          w_addr_load = 1'b1;
          w_next      = ST_WR_DATA;
        end
        ST_WR_DATA: begin
          w_wr_en   = 1'b1;
          w_wr_addr = r_addr;
          w_next    = ST_IDLE;
        end
        ST_RD_ADDR: begin
          w_reply_req  = 1'b1;
          w_reply_data = {{DATA_WIDTH{1'b0}}, r_regs[w_rx_data[AW-1:0]]};
          w_next       = ST_IDLE;
        end
        ST_OP_A: begin
          w_wr_en   = 1'b1;
          w_wr_addr = AW'(0);
          w_next    = ST_OP_B;
        end
        ST_OP_B: begin
          w_wr_en   = 1'b1;
          w_wr_addr = AW'(1);
          w_next    = ST_FUNC;
        end
        ST_FUNC: begin
          w_reply_req  = 1'b1;
          w_reply_two  = 1'b1;
          w_reply_data = w_alu_res;
          w_next       = ST_IDLE;
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge reference_clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      for (int unsigned i = 0; i < REGISTER_FILE_DEPTH; i++) r_regs[i] <= '0;
    end else begin
      r_state <= w_next;
      if (w_addr_load) r_addr <= w_rx_data[AW-1:0];
      if (w_wr_en)     r_regs[w_wr_addr] <= w_wr_data;
    end
  end

  logic                  r_tx_busy, r_tx_line;
  logic [DATA_WIDTH+1:0] r_tx_shift;
  logic [CW-1:0]         r_tx_cyc;
  logic [TBW-1:0]        r_tx_bit;
  logic [1:0]            r_cur_left;
  logic [RW-1:0]         r_cur_data, r_pend_data;
  logic                  r_pend_valid, r_pend_two;
  logic                  w_cur_idle;

  assign serial_data_out = r_tx_line;
  // A reply stays "current" until its last frame's stop bit ends; only then may the pending one follow.
  assign w_cur_idle = (r_cur_left == 2'd0) && !r_tx_busy;

  always_ff @(posedge reference_clk or negedge reset) begin
    if (!reset) begin
      r_tx_busy    <= 1'b0;
      r_tx_line    <= 1'b1;
      r_tx_shift   <= '1;
      r_tx_cyc     <= '0;
      r_tx_bit     <= '0;
      r_cur_left   <= 2'd0;
      r_cur_data   <= '0;
      r_pend_valid <= 1'b0;
      r_pend_two   <= 1'b0;
      r_pend_data  <= '0;
    end else begin
      if (w_cur_idle && r_pend_valid) begin
        r_cur_data   <= r_pend_data;
        r_cur_left   <= r_pend_two ? 2'd2 : 2'd1;
        r_pend_valid <= 1'b0;
      end
      if (w_reply_req) begin
        if (w_cur_idle && !r_pend_valid) begin
          r_cur_data <= w_reply_data;
          r_cur_left <= w_reply_two ? 2'd2 : 2'd1;
        end else if (!r_pend_valid || w_cur_idle) begin
          r_pend_data  <= w_reply_data;
          r_pend_two   <= w_reply_two;
          r_pend_valid <= 1'b1;
        end
      end
      if (!r_tx_busy && r_cur_left != 2'd0) begin
        r_tx_busy  <= 1'b1;
        r_tx_line  <= 1'b0;
        r_tx_shift <= {1'b1, ^r_cur_data[DATA_WIDTH-1:0], r_cur_data[DATA_WIDTH-1:0]};
        r_tx_cyc   <= '0;
        r_tx_bit   <= '0;
        r_cur_data <= r_cur_data >> DATA_WIDTH;
        r_cur_left <= r_cur_left - 2'd1;
      end else if (r_tx_busy) begin
        if (r_tx_cyc == LAST_CYC) begin
          r_tx_cyc <= '0;
          if (r_tx_bit == LAST_BIT) begin
            r_tx_busy <= 1'b0;
            r_tx_line <= 1'b1;
          end else begin
            r_tx_line  <= r_tx_shift[0];
            r_tx_shift <= {1'b1, r_tx_shift[DATA_WIDTH+1:1]};
            r_tx_bit   <= r_tx_bit + 1'b1;
          end
        end else begin
          r_tx_cyc <= r_tx_cyc + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_reg_alu_system.sv
// Directed bench for uart_reg_alu_system: serial command frames in, decoded reply frames checked.
module tb_uart_reg_alu_system;

  localparam int P = 8;

  logic clk, rst_n, sin, sout, perr, ferr;
  int   n_vec = 0;
  int   n_err = 0;
  int   perr_cnt = 0;
  int   ferr_cnt = 0;
  logic [9:0] rxq[$];

  uart_reg_alu_system #(
    .DATA_WIDTH              (8),
    .REGISTER_FILE_DEPTH     (16),
    .SYNCHRONIZER_STAGE_COUNT(2),
    .PRESCALE                (P)
  ) dut (
    .reference_clk  (clk),
    .reset          (rst_n),
    .serial_data_in (sin),
    .serial_data_out(sout),
    .parity_error   (perr),
    .frame_error    (ferr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (perr === 1'b1) perr_cnt++;
    if (ferr === 1'b1) ferr_cnt++;
  end

  // Line monitor: decodes each TX frame as {stop, parity, data}.
  initial begin
    logic [7:0] d;
    logic       p, s;
    forever begin
      @(negedge sout);
      repeat (P / 2) @(posedge clk);
      #1;
      if (sout === 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (P) @(posedge clk);
          #1 d[i] = sout;
        end
        repeat (P) @(posedge clk);
        #1 p = sout;
        repeat (P) @(posedge clk);
        #1 s = sout;
        rxq.push_back({s, p, d});
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop);
    @(negedge clk);
    sin = 1'b0;
    repeat (P) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      sin = d[i];
      repeat (P) @(negedge clk);
    end
    sin = (^d) ^ bad_par;
    repeat (P) @(negedge clk);
    sin = ~bad_stop;
    repeat (P) @(negedge clk);
    sin = 1'b1;
    repeat (P) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d);
    send_frame(d, 1'b0, 1'b0);
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] e);
    int t = 0;
    logic [9:0] f;
    while (rxq.size() == 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    if (rxq.size() == 0) begin
      check({tag, "_timeout"}, rxq.size(), 1);
    end else begin
      f = rxq.pop_front();
      check({tag, "_data"}, {24'h0, f[7:0]}, {24'h0, e});
      check({tag, "_parity"}, {31'h0, f[8]}, {31'h0, ^e});
      check({tag, "_stop"}, {31'h0, f[9]}, 32'h1);
    end
  endtask

  initial begin
    int t;
    rst_n = 1'b0;
    sin   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx_idle", {31'h0, sout}, 32'h1);
    check("reset_perr", {31'h0, perr}, 32'h0);
    check("reset_ferr", {31'h0, ferr}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // write then read back
    send(8'hAA); send(8'h05); send(8'h3C);
    send(8'hBB); send(8'h05);
    expect_frame("rd_reg5", 8'h3C);

    // ADD 0A+03, then MUL on held operands, then a read queued behind it
    send(8'hCC); send(8'h0A); send(8'h03); send(8'h00);
    expect_frame("add_lo", 8'h0D);
    expect_frame("add_hi", 8'h00);
    send(8'hDD); send(8'h02);
    send(8'hBB); send(8'h05);
    expect_frame("mul_lo", 8'h1E);
    expect_frame("mul_hi", 8'h00);
    expect_frame("rd_after_mul", 8'h3C);

    // widest product
    send(8'hCC); send(8'hFF); send(8'hFF); send(8'h02);
    expect_frame("mulff_lo", 8'h01);
    expect_frame("mulff_hi", 8'hFE);

    // divide by zero
    send(8'hCC); send(8'h07); send(8'h00); send(8'h03);
    expect_frame("div0_lo", 8'h00);
    expect_frame("div0_hi", 8'h00);

    // compare and shift on reg0=07 reg1=00
    send(8'hDD); send(8'h0B);
    expect_frame("gt_lo", 8'h01);
    expect_frame("gt_hi", 8'h00);
    send(8'hDD); send(8'h0E);
    expect_frame("shl_lo", 8'h0E);
    expect_frame("shl_hi", 8'h00);

    // bad-parity byte inside a read command is discarded
    send(8'hBB);
    send_frame(8'h55, 1'b1, 1'b0);
    repeat (10) @(posedge clk);
    check("perr_pulse", perr_cnt, 1);
    check("perr_no_ferr", ferr_cnt, 0);
    check("perr_no_reply", rxq.size(), 0);
    send(8'h00);
    expect_frame("rd_reg0_after_perr", 8'h07);

    // stop bit 0
    send_frame(8'h05, 1'b0, 1'b1);
    repeat (10) @(posedge clk);
    check("ferr_pulse", ferr_cnt, 1);
    check("ferr_no_perr", perr_cnt, 1);
    check("ferr_no_reply", rxq.size(), 0);
    send(8'hBB); send(8'h00);
    expect_frame("rd_reg0_after_ferr", 8'h07);

    // reset during transmission
    send(8'hBB); send(8'h05);
    t = 0;
    while (sout !== 1'b0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    check("tx_started", {31'h0, sout}, 32'h0);
    repeat (20) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1 check("reset_mid_tx_async", {31'h0, sout}, 32'h1);
    @(posedge clk);
    #1 check("reset_mid_tx_next", {31'h0, sout}, 32'h1);
    @(negedge clk) rst_n = 1'b1;
    repeat (150) @(posedge clk);
    rxq.delete();
    send(8'hBB); send(8'h05);
    expect_frame("rd_reg5_after_reset", 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
